// File: rtl/df_sequencer_if.sv
// df_sequencer_if: command handshake and Data_Fetch control bundle for df_sequencer.
interface df_sequencer_if;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_STORE;
  logic [1:0]  CMD_DIMEN;
  logic [16:0] CMD_ADDRESS;
  logic [1:0]  CMD_PE_SEL;
  logic        CMD_SEL_2x2;
  logic        CMD_SEL_4;
  logic        CMD_DONE;
  logic        CMD_ERR;
  logic        BUSY;
  logic [1:0]  DIMEN;
  logic [16:0] ADDRESS;
  logic [1:0]  PE_SEL;
  logic        PE_SEL_2x2;
  logic        PE_SEL_4;
  logic        ADDR_RST;
  logic        ADDR_START;
  logic        WRADDR_START;
  logic        FETCH_DONE;
  logic        STORE_DONE;
  modport slave (
    input  CMD_VALID, CMD_STORE, CMD_DIMEN, CMD_ADDRESS, CMD_PE_SEL, CMD_SEL_2x2, CMD_SEL_4,
           FETCH_DONE, STORE_DONE,
    output CMD_READY, CMD_DONE, CMD_ERR, BUSY, DIMEN, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4,
           ADDR_RST, ADDR_START, WRADDR_START
  );
  modport master (
    output CMD_VALID, CMD_STORE, CMD_DIMEN, CMD_ADDRESS, CMD_PE_SEL, CMD_SEL_2x2, CMD_SEL_4,
           FETCH_DONE, STORE_DONE,
    input  CMD_READY, CMD_DONE, CMD_ERR, BUSY, DIMEN, ADDRESS, PE_SEL, PE_SEL_2x2, PE_SEL_4,
           ADDR_RST, ADDR_START, WRADDR_START
  );
endinterface

// File: rtl/df_sequencer.sv
// df_sequencer: command-level load/store controller bracketing Data_Fetch transfers with address resets and a timeout.
module df_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W = 7
) (
  input logic CLK,
  input logic RST,
  df_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARST, RUN_LD, RUN_ST, FINISH} state_t;
  state_t state;
  logic [TO_W-1:0] cnt;
  logic store_q, err_q, rst_q, done_in;
  logic [1:0] dimen_q, pe_sel_q;
  logic [16:0] addr_q;
  logic sel2_q, sel4_q;
  assign done_in = state == RUN_LD ? bus.FETCH_DONE : bus.STORE_DONE;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      store_q <= 1'b0;
      err_q <= 1'b0;
      rst_q <= 1'b1;
      dimen_q <= '0;
      addr_q <= '0;
      pe_sel_q <= '0;
      sel2_q <= 1'b0;
      sel4_q <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      case (state)
        IDLE: if (bus.CMD_VALID) begin
          store_q <= bus.CMD_STORE;
          dimen_q <= bus.CMD_DIMEN;
          addr_q <= bus.CMD_ADDRESS;
          pe_sel_q <= bus.CMD_PE_SEL;
          sel2_q <= bus.CMD_SEL_2x2;
          sel4_q <= bus.CMD_SEL_4;
          err_q <= 1'b0;
          state <= ARST;
        end
        ARST: begin
          cnt <= '0;
          state <= store_q ? RUN_ST : RUN_LD;
        end
        RUN_LD, RUN_ST: begin
          cnt <= cnt + 1'b1;
          // a done arriving on the final timeout cycle still counts as success
          if (done_in) begin
            err_q <= 1'b0;
            state <= FINISH;
          end else if (cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_q <= 1'b1;
            state <= FINISH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.CMD_READY = state == IDLE;
  assign bus.BUSY = state != IDLE;
  assign bus.CMD_DONE = state == FINISH;
  assign bus.CMD_ERR = state == FINISH && err_q;
  assign bus.ADDR_START = state == RUN_LD;
  assign bus.WRADDR_START = state == RUN_ST;
  assign bus.ADDR_RST = rst_q || state == ARST || state == FINISH;
  assign bus.DIMEN = dimen_q;
  assign bus.ADDRESS = addr_q;
  assign bus.PE_SEL = pe_sel_q;
  assign bus.PE_SEL_2x2 = sel2_q;
  assign bus.PE_SEL_4 = sel4_q;
endmodule

// File: tb/tb_df_sequencer.sv
// tb_df_sequencer: directed stimulus with a completion scoreboard checked by an independent monitor.
module tb_df_sequencer;
  localparam int TO = 64;
  typedef struct packed {
    logic err;
    logic [1:0] dim;
    logic [16:0] addr;
    logic [1:0] ps;
    logic s2;
    logic s4;
  } resp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  resp_t q[$];
  df_sequencer_if bus();
  df_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(7)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic st, input logic [1:0] dim, input logic [16:0] addr,
                           input logic [1:0] ps, input logic s2, input logic s4);
    bus.CMD_STORE = st;
    bus.CMD_DIMEN = dim;
    bus.CMD_ADDRESS = addr;
    bus.CMD_PE_SEL = ps;
    bus.CMD_SEL_2x2 = s2;
    bus.CMD_SEL_4 = s4;
  endtask

  // entered during the ARST cycle; done_after = 0 means done never arrives
  task automatic run_phase(input logic st, input logic [16:0] addr, input int done_after, input logic err);
    int lim;
    lim = done_after != 0 ? done_after : TO;
    check("arst_addr_rst", bus.ADDR_RST, 1);
    check("arst_enables", {bus.ADDR_START, bus.WRADDR_START}, 0);
    check("arst_ready", bus.CMD_READY, 0);
    for (int n = 1; n <= lim; n++) begin
      tick();
      check("run_enables", {bus.ADDR_START, bus.WRADDR_START}, st ? 2'b01 : 2'b10);
      check("run_addr_rst", bus.ADDR_RST, 0);
      check("run_address", bus.ADDRESS, addr);
      check("run_done", bus.CMD_DONE, 0);
      if (n == done_after) begin
        if (st) bus.STORE_DONE = 1'b1;
        else bus.FETCH_DONE = 1'b1;
      end
    end
    tick();
    bus.FETCH_DONE = 1'b0;
    bus.STORE_DONE = 1'b0;
    check("fin_done", bus.CMD_DONE, 1);
    check("fin_err", bus.CMD_ERR, err);
    check("fin_enables", {bus.ADDR_START, bus.WRADDR_START}, 0);
    check("fin_addr_rst", bus.ADDR_RST, 1);
    tick();
    check("idle_ready", bus.CMD_READY, 1);
    check("idle_busy", bus.BUSY, 0);
  endtask

  task automatic do_cmd(input logic st, input logic [1:0] dim, input logic [16:0] addr,
                        input logic [1:0] ps, input logic s2, input logic s4,
                        input int done_after, input logic err);
    drive_cmd(st, dim, addr, ps, s2, s4);
    bus.CMD_VALID = 1'b1;
    q.push_back('{err, dim, addr, ps, s2, s4});
    tick();
    bus.CMD_VALID = 1'b0;
    run_phase(st, addr, done_after, err);
  endtask

  always @(posedge clk) begin
    resp_t e;
    #2;
    if (!rst) begin
      check("excl_enables", bus.ADDR_START & bus.WRADDR_START, 0);
      check("enable_vs_rst", (bus.ADDR_START | bus.WRADDR_START) & bus.ADDR_RST, 0);
    end
    if (bus.CMD_DONE === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: CMD_DONE=1 with no command outstanding at %0t", $time);
      end else begin
        e = q.pop_front();
        check("sb_resp", {bus.CMD_ERR, bus.DIMEN, bus.ADDRESS, bus.PE_SEL, bus.PE_SEL_2x2, bus.PE_SEL_4}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CMD_VALID = 1'b0;
    bus.FETCH_DONE = 1'b0;
    bus.STORE_DONE = 1'b0;
    drive_cmd(1'b0, 2'd0, 17'h0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_addr_rst", bus.ADDR_RST, 1);
      check("rst_enables", {bus.ADDR_START, bus.WRADDR_START, bus.CMD_DONE, bus.CMD_ERR, bus.BUSY}, 0);
    end
    rst = 1'b0;
    check("post_rst_ready", bus.CMD_READY, 1);
    check("post_rst_cfg", {bus.DIMEN, bus.ADDRESS, bus.PE_SEL, bus.PE_SEL_2x2, bus.PE_SEL_4}, 0);
    tick();
    do_cmd(1'b0, 2'd0, 17'h00100, 2'd2, 1'b1, 1'b0, 7, 1'b0);
    do_cmd(1'b1, 2'd1, 17'h00200, 2'd1, 1'b0, 1'b1, 2, 1'b0);
    do_cmd(1'b0, 2'd1, 17'h00500, 2'd1, 1'b0, 1'b1, 0, 1'b1);
    do_cmd(1'b1, 2'd3, 17'h1ABCD, 2'd3, 1'b1, 1'b1, TO, 1'b0);
    // held CMD_VALID with fields swapped mid-operation, plus a premature FETCH_DONE in ARST
    drive_cmd(1'b0, 2'd1, 17'h00300, 2'd0, 1'b1, 1'b0);
    bus.CMD_VALID = 1'b1;
    q.push_back('{1'b0, 2'd1, 17'h00300, 2'd0, 1'b1, 1'b0});
    tick();
    drive_cmd(1'b1, 2'd3, 17'h00400, 2'd3, 1'b0, 1'b1);
    bus.FETCH_DONE = 1'b1;
    tick();
    bus.FETCH_DONE = 1'b0;
    check("hs_arst_done_ignored", bus.ADDR_START, 1);
    for (int i = 0; i < 2; i++) begin
      check("hs_ready", bus.CMD_READY, 0);
      check("hs_address_held", bus.ADDRESS, 17'h00300);
      check("hs_dimen_held", bus.DIMEN, 2'd1);
      tick();
    end
    bus.FETCH_DONE = 1'b1;
    tick();
    bus.FETCH_DONE = 1'b0;
    check("hs_done", bus.CMD_DONE, 1);
    q.push_back('{1'b0, 2'd3, 17'h00400, 2'd3, 1'b0, 1'b1});
    tick();
    check("hs_idle_ready", bus.CMD_READY, 1);
    check("hs_idle_address", bus.ADDRESS, 17'h00300);
    tick();
    bus.CMD_VALID = 1'b0;
    check("hs_new_address", bus.ADDRESS, 17'h00400);
    run_phase(1'b1, 17'h00400, 3, 1'b0);
    // abort mid-load with reset; no completion may be reported
    drive_cmd(1'b0, 2'd2, 17'h00600, 2'd1, 1'b1, 1'b1);
    bus.CMD_VALID = 1'b1;
    tick();
    bus.CMD_VALID = 1'b0;
    tick();
    tick();
    check("abort_running", bus.ADDR_START, 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_addr_rst", bus.ADDR_RST, 1);
      check("abort_outputs", {bus.ADDR_START, bus.WRADDR_START, bus.CMD_DONE, bus.BUSY}, 0);
      check("abort_cfg_clear", bus.ADDRESS, 0);
    end
    rst = 1'b0;
    check("abort_ready", bus.CMD_READY, 1);
    tick();
    do_cmd(1'b0, 2'd2, 17'h00800, 2'd1, 1'b0, 1'b0, 5, 1'b0);
    tick();
    check("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
